text_buf_engine: RTL

//  Range fill/copy engine for the 80x25 character buffer. Consumes one command from the terminal parser:

---
 rtl/term_pkg.sv | 26 ++
 rtl/text_buf_engine_if.sv | 30 +++
 rtl/text_buf_engine.sv | 99 +++++++++
 3 files changed

// File: rtl/term_pkg.sv
// Shared terminal constants: screen geometry, character buffer addressing and
// the range engine's state encodings.
package term_pkg;

    localparam int COLS   = 80;
    localparam int ROWS   = 25;
    localparam int DEPTH  = COLS * ROWS;
    localparam int ADDR_W = 11;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_COPY = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam cnt_t CNT_ONE   = cnt_t'(1);
    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    // One extra bit keeps dst+offset-1 from wrapping for any dst/offset pair.
    function automatic cnt_t src_addr(input cnt_t dst, input logic [7:0] offset);
        return dst + cnt_t'(offset) - CNT_ONE;
    endfunction

endpackage

// File: rtl/text_buf_engine_if.sv
// Command and character-RAM signals of the range fill/copy engine.
interface text_buf_engine_if;
    import term_pkg::*;

    logic       wr_start;
    addr_t      wr_begin;
    addr_t      wr_end;
    logic [7:0] wr_data;
    logic [7:0] wr_offset;
    logic       wr_complete;
    logic       busy;
    logic       rd_stall;
    logic       buf_rd_en;
    addr_t      buf_rd_addr;
    logic [7:0] buf_rd_data;
    logic       buf_wr_en;
    addr_t      buf_wr_addr;
    logic [7:0] buf_wr_data;

    modport master (
        output wr_start, wr_begin, wr_end, wr_data, wr_offset, rd_stall, buf_rd_data,
        input  wr_complete, busy, buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, buf_wr_data
    );

    modport slave (
        input  wr_start, wr_begin, wr_end, wr_data, wr_offset, rd_stall, buf_rd_data,
        output wr_complete, busy, buf_rd_en, buf_rd_addr, buf_wr_en, buf_wr_addr, buf_wr_data
    );

endinterface

// File: rtl/text_buf_engine.sv
// Range fill/copy engine for the 80x25 character buffer: turns one parser command
// into ascending-order buffer writes (fill) or read-then-write pairs (copy).
module text_buf_engine (
    input  logic              clk100,
    input  logic              rst,
    text_buf_engine_if.slave  bus
);
    import term_pkg::*;

    logic [1:0] state;
    cnt_t       end_q;
    logic [7:0] fill_q;
    logic [7:0] offset_q;
    cnt_t       dst;

    logic       vld_p1;
    logic       zero_p1;
    cnt_t       addr_p1;

    cnt_t       src;
    logic       src_oob;
    logic       issue;
    logic       rd_go;
    logic       last_fill;
    logic       last_copy;
    logic       wr_fill;
    logic       wr_copy;

    // Out-of-range sources skip the read port entirely, so stall cannot hold them.
    always_comb begin
        src       = src_addr(dst, offset_q);
        src_oob   = (src >= DEPTH_CNT);
        issue     = (state == ST_COPY) && (dst != end_q) && (src_oob || !bus.rd_stall);
        rd_go     = issue && !src_oob;
        last_fill = (dst + CNT_ONE == end_q);
        last_copy = vld_p1 && (addr_p1 + CNT_ONE == end_q);
        wr_fill   = (state == ST_FILL);
        wr_copy   = (state == ST_COPY) && vld_p1;
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state  <= ST_IDLE;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.wr_start) begin
                        if (bus.wr_begin >= bus.wr_end) begin
                            state <= ST_DONE;
                        end else if (bus.wr_offset == 8'd0) begin
                            state <= ST_FILL;
                        end else begin
                            state <= ST_COPY;
                        end
                    end
                end
                ST_FILL: begin
                    if (last_fill) begin
                        state <= ST_DONE;
                    end
                end
                ST_COPY: begin
                    vld_p1 <= issue;
                    if (last_copy) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // p0 -> p1: issued cell address and its zero-source flag follow the read by one cycle.
    always_ff @(posedge clk100) begin
        if (state == ST_IDLE && bus.wr_start) begin
            end_q    <= {1'b0, bus.wr_end};
            fill_q   <= bus.wr_data;
            offset_q <= bus.wr_offset;
            dst      <= {1'b0, bus.wr_begin};
        end else if (wr_fill || issue) begin
            dst <= dst + CNT_ONE;
        end
        addr_p1 <= dst;
        zero_p1 <= src_oob;
    end

    assign bus.wr_complete = (state == ST_DONE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.buf_rd_en   = rd_go;
    assign bus.buf_rd_addr = rd_go ? src[ADDR_W-1:0] : '0;
    assign bus.buf_wr_en   = wr_fill || wr_copy;
    assign bus.buf_wr_addr = wr_fill ? dst[ADDR_W-1:0] :
                             (wr_copy ? addr_p1[ADDR_W-1:0] : '0);
    assign bus.buf_wr_data = wr_fill ? fill_q :
                             ((wr_copy && !zero_p1) ? bus.buf_rd_data : 8'd0);

endmodule
